// File: rtl/prf_free_list.sv
// rtl/prf_free_list.sv - circular free list of physical register ids between retire and rename
module prf_free_list #(
  parameter int NUM_PRF  = 64,
  parameter int NUM_GPR  = 32,
  parameter int FL_DEPTH = NUM_PRF - NUM_GPR,
  localparam int PW      = $clog2(NUM_PRF),
  localparam int AW      = $clog2(FL_DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_ra0,
  output logic          alloc_ready_ra0,
  output logic [PW-1:0] alloc_prf_id_ra0,
  input  logic          reclaim_prf_rb1,
  input  logic [PW-1:0] reclaim_prf_id_rb1,
  input  logic          nuke_valid_rb1,
  output logic [CW-1:0] free_count
);

  // The wrap bit in each pointer only works if the index wraps exactly at FL_DEPTH.
  generate
    if (FL_DEPTH < 2 || (FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("prf_free_list: FL_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [PW-1:0] mem [FL_DEPTH];

  // Pointers are {wrap, idx}; [commit_head, spec_head) holds in-flight allocations,
  // [spec_head, tail) holds ids rename may still hand out.
  logic [CW-1:0] spec_head, commit_head, tail;
  logic [CW-1:0] spec_head_nxt, commit_head_nxt, tail_nxt;
  logic          do_alloc;

  assign alloc_ready_ra0  = (spec_head != tail);
  assign alloc_prf_id_ra0 = mem[spec_head[AW-1:0]];
  assign free_count       = tail - spec_head;

  // Next pointers: a nuke rewinds to the committed point (including a same-cycle retire)
  // and swallows any allocation attempted in that cycle.
  always_comb begin
    do_alloc        = alloc_ra0 & alloc_ready_ra0 & ~nuke_valid_rb1;
    commit_head_nxt = commit_head + CW'(reclaim_prf_rb1);
    tail_nxt        = tail + CW'(reclaim_prf_rb1);
    spec_head_nxt   = spec_head + CW'(do_alloc);
    if (nuke_valid_rb1) begin
      spec_head_nxt = commit_head_nxt;
    end
  end

  // Pointer registers; reset leaves the list full of the non-architectural ids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= CW'(FL_DEPTH);
    end else begin
      spec_head   <= spec_head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
    end
  end

  // Storage: a retiring uop's old pdst lands at tail, overwriting the slot of its own allocation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PW'(NUM_GPR + i);
      end
    end else if (reclaim_prf_rb1) begin
      mem[tail[AW-1:0]] <= reclaim_prf_id_rb1;
    end
  end

`ifndef SYNTHESIS
  // Protocol and pointer-ordering checks. tail - commit_head is held at FL_DEPTH by
  // construction, so a retire with nothing in flight (spec_head == commit_head) is the overflow case.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(alloc_ra0 && !alloc_ready_ra0))
        else $error("prf_free_list: alloc_ra0 while list empty");
      assert (!reclaim_prf_rb1 || ({1'b0, reclaim_prf_id_rb1} < (PW+1)'(NUM_PRF)))
        else $error("prf_free_list: reclaimed id out of range");
      assert ((spec_head - commit_head) <= (tail - commit_head))
        else $error("prf_free_list: pointer order broken");
      assert ((tail - commit_head) <= CW'(FL_DEPTH))
        else $error("prf_free_list: tail ahead of commit_head by more than FL_DEPTH");
      assert (!reclaim_prf_rb1 || (spec_head != commit_head))
        else $error("prf_free_list: reclaim overflow");
    end
  end

`ifdef PRF_FL_UINFO
  logic [CW-1:0] free_count_nxt;
  assign free_count_nxt = tail_nxt - spec_head_nxt;

  // Trace of list activity for debug runs.
  always @(posedge clk) begin
    if (reset) begin
      if (do_alloc)
        $info("UINFO alloc id=%0d free_count=%0d", alloc_prf_id_ra0, free_count_nxt);
      if (reclaim_prf_rb1)
        $info("UINFO reclaim id=%0d free_count=%0d", reclaim_prf_id_rb1, free_count_nxt);
      if (nuke_valid_rb1)
        $info("UINFO nuke id=%0d free_count=%0d", mem[spec_head_nxt[AW-1:0]], free_count_nxt);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// tb/tb_prf_free_list.sv - scoreboard bench for prf_free_list against a queue-based model
module tb_prf_free_list;
  localparam int NUM_PRF  = 64;
  localparam int NUM_GPR  = 32;
  localparam int FL_DEPTH = 32;
  localparam int PW       = 6;
  localparam int CW       = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alloc_ra0 = 1'b0;
  logic          alloc_ready_ra0;
  logic [PW-1:0] alloc_prf_id_ra0;
  logic          reclaim_prf_rb1 = 1'b0;
  logic [PW-1:0] reclaim_prf_id_rb1 = '0;
  logic          nuke_valid_rb1 = 1'b0;
  logic [CW-1:0] free_count;

  prf_free_list #(.NUM_PRF(NUM_PRF), .NUM_GPR(NUM_GPR), .FL_DEPTH(FL_DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_ra0         (alloc_ra0),
    .alloc_ready_ra0   (alloc_ready_ra0),
    .alloc_prf_id_ra0  (alloc_prf_id_ra0),
    .reclaim_prf_rb1   (reclaim_prf_rb1),
    .reclaim_prf_id_rb1(reclaim_prf_id_rb1),
    .nuke_valid_rb1    (nuke_valid_rb1),
    .free_count        (free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    ready;
    int    id;
    int    count;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  int    free_q[$];   // ids rename may take, in hand-out order
  int    infl_q[$];   // ids handed out and not yet retired, oldest first
  int    pool_q[$];   // ids currently mapped to architectural state
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "reset";

  function automatic void model_reset();
    free_q.delete();
    infl_q.delete();
    pool_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) free_q.push_back(NUM_GPR + i);
    for (int i = 0; i < NUM_GPR; i++) pool_q.push_back(i);
  endfunction

  task automatic push_exp();
    exp_t e;
    e.ready = (free_q.size() > 0);
    e.id    = e.ready ? free_q[0] : 0;
    e.count = free_q.size();
    e.tag   = cur_tag;
    exp_q.push_back(e);
  endtask

  // One cycle: record what the DUT should show now, then drive inputs and advance the model.
  // rid < 0 picks a random architecturally mapped id to free.
  task automatic step(input bit a, input bit r, input int rid, input bit nk);
    bit do_a;
    int id;
    int x;
    @(posedge clk);
    #1;
    push_exp();
    do_a = a && (free_q.size() > 0) && !nk;
    if (do_a) begin
      n_checks++;
      foreach (infl_q[k]) begin
        if (infl_q[k] == int'(alloc_prf_id_ra0)) begin
          n_fail++;
          $display("FAIL %s dup_alloc: got id %0d which is still outstanding", cur_tag, alloc_prf_id_ra0);
          break;
        end
      end
    end
    id = rid;
    if (r) begin
      if (rid < 0) begin
        x  = int'($urandom_range(pool_q.size() - 1, 0));
        id = pool_q[x];
        pool_q.delete(x);
      end else begin
        foreach (pool_q[k]) if (pool_q[k] == rid) begin pool_q.delete(k); break; end
      end
    end
    alloc_ra0          = a && (free_q.size() > 0);
    reclaim_prf_rb1    = r;
    reclaim_prf_id_rb1 = PW'(r ? id : 0);
    nuke_valid_rb1     = nk;
    if (do_a) begin
      x = free_q.pop_front();
      infl_q.push_back(x);
    end
    if (r) begin
      x = infl_q.pop_front();
      pool_q.push_back(x);
      free_q.push_back(id);
    end
    if (nk) begin
      free_q = {infl_q, free_q};
      infl_q.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b0;
    alloc_ra0 = 1'b0; reclaim_prf_rb1 = 1'b0; nuke_valid_rb1 = 1'b0; reclaim_prf_id_rb1 = '0;
    model_reset();
    push_exp();
    repeat (cycles - 1) begin
      @(posedge clk);
      #1;
      push_exp();
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_exp();
  endtask

  // Monitor: compare the DUT's visible state mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (alloc_ready_ra0 !== e.ready) begin
          n_fail++;
          $display("FAIL %s ready: got %0b expected %0b", e.tag, alloc_ready_ra0, e.ready);
        end
        n_checks++;
        if (free_count !== CW'(e.count)) begin
          n_fail++;
          $display("FAIL %s free_count: got %0d expected %0d", e.tag, free_count, e.count);
        end
        if (e.ready) begin
          n_checks++;
          if (alloc_prf_id_ra0 !== PW'(e.id)) begin
            n_fail++;
            $display("FAIL %s alloc_id: got %0d expected %0d", e.tag, alloc_prf_id_ra0, e.id);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    model_reset();

    cur_tag = "reset";
    do_reset(2);

    cur_tag = "drain";
    repeat (32) step(1, 0, 0, 0);
    cur_tag = "empty";
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    cur_tag = "reclaim_from_empty";
    step(0, 1, 5, 0);
    step(0, 1, 9, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    cur_tag = "nuke_rewind";
    do_reset(1);
    repeat (10) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(0, 1, 8, 0);
    step(0, 1, 9, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    cur_tag = "nuke_reclaim_alloc";
    repeat (3) step(1, 0, 0, 0);
    step(0, 1, -1, 0);
    step(1, 1, -1, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    cur_tag = "random";
    for (int i = 0; i < 200; i++) begin
      bit a, r, nk;
      a  = ($urandom % 2) == 1;
      r  = (infl_q.size() > 0) && (($urandom % 2) == 1);
      nk = ($urandom % 32) == 0;
      step(a, r, -1, nk);
    end

    cur_tag = "approach7";
    for (int i = 0; i < 64 && free_q.size() != 7; i++) begin
      if (free_q.size() > 7) step(1, 0, 0, 0);
      else                   step(0, 1, -1, 0);
    end
    step(0, 0, 0, 0);
    cur_tag = "mid_reset";
    do_reset(1);
    cur_tag = "post_reset";
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
